// File: rtl/demux2_pkg.sv
// Shared types and constants for the two-way packet stream demultiplexer.
package demux2_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/demux2_slot.sv
// One-entry output register for a single channel: holds valid/data/last
// until the sink takes it, and reports whether it can take a new beat now.
module demux2_slot
  import demux2_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last,
  output logic          space_c
);

  // Free this cycle if empty or draining, so refill and drain can overlap.
  assign space_c = !valid || ready;

  // Output register: load wins over drain so back-to-back beats have no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// Two-way packet demultiplexer: the first beat's select steers the whole
// packet to channel 0 or 1. Optional per-channel delivered-beat counters
// are built when DEMUX2_STREAM_CNT_EN is defined.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DW-1:0]    i_data,
  input  logic             i_last,
  input  logic             i_sel,
  output logic             o_valid0,
  input  logic             i_ready0,
  output logic [DW-1:0]    o_data0,
  output logic             o_last0,
  output logic             o_valid1,
  input  logic             i_ready1,
  output logic [DW-1:0]    o_data1,
  output logic             o_last1,
`ifdef DEMUX2_STREAM_CNT_EN
  output logic [CNT_W-1:0] o_cnt0,
  output logic [CNT_W-1:0] o_cnt1,
`endif
  output logic             o_busy
);

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   target_c;
  logic   space0_c, space1_c;
  logic   accept_c;

  // Packet target: live select on a packet start, latched select mid-packet.
  assign target_c = (state_q == LOCK) ? sel_q : i_sel;
  assign o_ready  = target_c ? space1_c : space0_c;
  assign accept_c = i_valid && o_ready;
  assign o_busy   = (state_q == LOCK);

  // State and latched-select registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state: lock onto a destination for multi-beat packets.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (accept_c && !i_last) begin
          state_d = LOCK;
          sel_d   = i_sel;
        end
      end
      LOCK: begin
        if (accept_c && i_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  demux2_slot #(.DW(DW)) u_slot0 (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (accept_c && !target_c),
    .load_data (i_data),
    .load_last (i_last),
    .ready     (i_ready0),
    .valid     (o_valid0),
    .data      (o_data0),
    .last      (o_last0),
    .space_c   (space0_c)
  );

  demux2_slot #(.DW(DW)) u_slot1 (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (accept_c && target_c),
    .load_data (i_data),
    .load_last (i_last),
    .ready     (i_ready1),
    .valid     (o_valid1),
    .data      (o_data1),
    .last      (o_last1),
    .space_c   (space1_c)
  );

`ifdef DEMUX2_STREAM_CNT_EN
  // Delivered-beat counters, wrapping naturally at the counter width.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt0 <= '0;
      o_cnt1 <= '0;
    end else begin
      if (o_valid0 && i_ready0) o_cnt0 <= o_cnt0 + CNT_W'(1);
      if (o_valid1 && i_ready1) o_cnt1 <= o_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: packet-level reference model compared every cycle,
// plus directed scenarios with literal expectations and a random phase.
module tb_demux2_stream;
  import demux2_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_last, i_sel, i_ready0, i_ready1;
  logic [DW-1:0] i_data;
  logic          o_ready, o_valid0, o_valid1, o_last0, o_last1, o_busy;
  logic [DW-1:0] o_data0, o_data1;
`ifdef DEMUX2_STREAM_CNT_EN
  logic [15:0]   o_cnt0, o_cnt1;
`endif

  int n_vec = 0;
  int n_err = 0;

  demux2_stream #(.DW(DW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_last   (i_last),
    .i_sel    (i_sel),
    .o_valid0 (o_valid0),
    .i_ready0 (i_ready0),
    .o_data0  (o_data0),
    .o_last0  (o_last0),
    .o_valid1 (o_valid1),
    .i_ready1 (i_ready1),
    .o_data1  (o_data1),
    .o_last1  (o_last1),
`ifdef DEMUX2_STREAM_CNT_EN
    .o_cnt0   (o_cnt0),
    .o_cnt1   (o_cnt1),
`endif
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one pending beat per channel, packet destination memory.
  logic          m_val [2] = '{1'b0, 1'b0};
  logic [DW-1:0] m_dat [2] = '{8'h00, 8'h00};
  logic          m_lst [2] = '{1'b0, 1'b0};
  logic [15:0]   m_cnt [2] = '{16'h0, 16'h0};
  logic          m_in_pkt = 1'b0;
  logic          m_dst    = 1'b0;

  function automatic logic m_target();
    return m_in_pkt ? m_dst : i_sel;
  endfunction

  function automatic logic m_ready();
    logic t;
    logic r;
    t = m_target();
    r = t ? i_ready1 : i_ready0;
    return !m_val[t] || r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        m_val[n] = 1'b0; m_dat[n] = '0; m_lst[n] = 1'b0; m_cnt[n] = '0;
      end
      m_in_pkt = 1'b0;
      m_dst    = 1'b0;
    end else begin
      logic t, acc;
      logic rdy [2];
      rdy[0] = i_ready0;
      rdy[1] = i_ready1;
      t   = m_target();
      acc = i_valid && m_ready();
      for (int n = 0; n < 2; n++) begin
        if (m_val[n] && rdy[n]) begin
          m_val[n] = 1'b0;
          m_cnt[n] = m_cnt[n] + 16'd1;
        end
      end
      if (acc) begin
        m_val[t] = 1'b1;
        m_dat[t] = i_data;
        m_lst[t] = i_last;
        if (!m_in_pkt && !i_last) begin
          m_in_pkt = 1'b1;
          m_dst    = i_sel;
        end else if (m_in_pkt && i_last) begin
          m_in_pkt = 1'b0;
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("ready",  32'(o_ready),  32'(m_ready()));
    chk("valid0", 32'(o_valid0), 32'(m_val[0]));
    chk("valid1", 32'(o_valid1), 32'(m_val[1]));
    chk("data0",  32'(o_data0),  32'(m_dat[0]));
    chk("data1",  32'(o_data1),  32'(m_dat[1]));
    chk("last0",  32'(o_last0),  32'(m_lst[0]));
    chk("last1",  32'(o_last1),  32'(m_lst[1]));
    chk("busy",   32'(o_busy),   32'(m_in_pkt));
`ifdef DEMUX2_STREAM_CNT_EN
    chk("cnt0",   32'(o_cnt0),   32'(m_cnt[0]));
    chk("cnt1",   32'(o_cnt1),   32'(m_cnt[1]));
`endif
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l,
                       input logic s, input logic r0, input logic r1);
    i_valid = v; i_data = d; i_last = l; i_sel = s; i_ready0 = r0; i_ready1 = r1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_valid0", 32'(o_valid0), 32'd0);
    chk("rst_busy",   32'(o_busy),   32'd0);
    rst = 1'b0;
    tick();

    // Single beat to channel 1.
    drive(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk("t1_ready", 32'(o_ready), 32'd1);
    tick();
    chk("t1_valid1", 32'(o_valid1), 32'd1);
    chk("t1_data1",  32'(o_data1),  32'hA5);
    chk("t1_valid0", 32'(o_valid0), 32'd0);
    chk("t1_busy",   32'(o_busy),   32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // 4-beat packet locked to channel 0 despite select changing.
    for (int b = 1; b <= 4; b++) begin
      drive(1'b1, 8'(b), (b == 4), (b != 1), 1'b1, 1'b1);
      tick();
      chk("t2_valid0", 32'(o_valid0), 32'd1);
      chk("t2_data0",  32'(o_data0),  32'(b));
      chk("t2_valid1", 32'(o_valid1), 32'd0);
      chk("t2_busy",   32'(o_busy),   (b == 4) ? 32'd0 : 32'd1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // Stalled channel 0 holds its beat; channel 1 still flows.
    drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("t3_data0", 32'(o_data0), 32'h11);
    drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 chk("t3_ready0", 32'(o_ready), 32'd0);
    tick();
    chk("t3_hold0", 32'(o_data0), 32'h11);
    drive(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("t3_ready1", 32'(o_ready), 32'd1);
    tick();
    chk("t3_valid1", 32'(o_valid1), 32'd1);
    chk("t3_data1",  32'(o_data1),  32'h33);
    chk("t3_hold0b", 32'(o_data0),  32'h11);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // 8-beat continuous stream: one beat out per cycle.
    for (int b = 0; b < 8; b++) begin
      drive(1'b1, 8'(8'h40 + b), (b == 7), 1'b1, 1'b1, 1'b1);
      tick();
      chk("t4_valid1", 32'(o_valid1), 32'd1);
      chk("t4_data1",  32'(o_data1),  32'(8'h40 + b));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // Reset mid-packet discards buffered beats and the lock.
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("t5_busy_pre", 32'(o_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_valid0", 32'(o_valid0), 32'd0);
    chk("t5_valid1", 32'(o_valid1), 32'd0);
    chk("t5_busy",   32'(o_busy),   32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("t5_route1", 32'(o_valid1), 32'd1);
    chk("t5_data1",  32'(o_data1),  32'h77);
    chk("t5_quiet0", 32'(o_valid0), 32'd0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      drive(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 2) == 0),
            1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
      tick();
    end
    rst = 1'b0;

`ifdef DEMUX2_STREAM_CNT_EN
    // Counter wrap: 65537 deliveries to channel 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 65537; c++) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t6_cnt0", 32'(o_cnt0), 32'd1);
    chk("t6_cnt1", 32'(o_cnt1), 32'd0);
`endif

    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
